hs_pipe_n: RTL

Parametrised, clocked successor to the team's 3-stage and 6-stage req/ack pipeline blocks. It moves DATA_W-bit tokens through DEPTH register stages. Both ports use a four-phase, return-to-zero req/ack handshake, sampled on `clk`. It adds a synchronous flush and a live occupancy count, and sits between any two req/ack blocks in the datapath.

---
 rtl/hs_pipe_n.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hs_pipe_n.sv
// hs_pipe_n: DEPTH-stage req/ack token pipeline with synchronous flush and live occupancy.
// Latency: a token captured at edge E0 into an empty pipe raises req_out after edge E0+DEPTH.
// Backpressure: stages advance only into empty stages; with stage 0 full, req_in waits unacknowledged.
//
// Ports:
//   clk, rst (async, active-low)
//   req_in / data_in / ack_out  : four-phase upstream handshake
//   req_out / data_out / ack_in : four-phase downstream handshake
//   flush                       : synchronous discard of buffered tokens
//   count                       : registered number of full stages
module hs_pipe_n #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 6,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic {I_IDLE, I_ACK} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_WAIT} out_state_t;

  in_state_t   in_state, in_state_n;
  out_state_t  out_state, out_state_n;

  logic [DEPTH-1:0]  full, full_n;
  logic [DEPTH-1:0]  load;
  logic [DATA_W-1:0] stage_dat [DEPTH];

  logic              capture;
  logic              consume;
  logic              ack_out_n;
  logic              req_out_n;
  logic [CNT_W-1:0]  count_n;

  // Input side: one capture per four-phase handshake.
  always_comb begin
    in_state_n = in_state;
    ack_out_n  = ack_out;
    capture    = 1'b0;
    case (in_state)
      I_IDLE: begin
        if (req_in && !full[0] && !flush) begin
          capture    = 1'b1;
          ack_out_n  = 1'b1;
          in_state_n = I_ACK;
        end
      end
      I_ACK: begin
        if (!req_in) begin
          ack_out_n  = 1'b0;
          in_state_n = I_IDLE;
        end
      end
      default: begin
        ack_out_n  = 1'b0;
        in_state_n = I_IDLE;
      end
    endcase
  end

  // Output side. A flush in O_IDLE empties the last stage, so no new
  // request may be launched for it on that edge.
  always_comb begin
    out_state_n = out_state;
    req_out_n   = req_out;
    consume     = 1'b0;
    case (out_state)
      O_IDLE: begin
        if (full[DEPTH-1] && !flush) begin
          req_out_n   = 1'b1;
          out_state_n = O_REQ;
        end
      end
      O_REQ: begin
        if (ack_in) begin
          req_out_n   = 1'b0;
          consume     = 1'b1;
          out_state_n = O_WAIT;
        end
      end
      O_WAIT: begin
        if (!ack_in) out_state_n = O_IDLE;
      end
      default: begin
        req_out_n   = 1'b0;
        out_state_n = O_IDLE;
      end
    endcase
  end

  // Next-state full flags. Advances look only at start-of-cycle flags, so a
  // stage that is vacating this edge cannot be refilled on the same edge.
  always_comb begin
    full_n = full;
    load   = '0;
    if (flush) begin
      for (int k = 0; k < DEPTH - 1; k++) full_n[k] = 1'b0;
      // A token already offered downstream survives so its handshake completes.
      if (out_state == O_IDLE) full_n[DEPTH-1] = 1'b0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if (full[k-1] && !full[k]) begin
          load[k]     = 1'b1;
          full_n[k]   = 1'b1;
          full_n[k-1] = 1'b0;
        end
      end
      if (capture) begin
        load[0]   = 1'b1;
        full_n[0] = 1'b1;
      end
    end
    if (consume) full_n[DEPTH-1] = 1'b0;
  end

  always_comb begin
    count_n = '0;
    for (int k = 0; k < DEPTH; k++) count_n = count_n + CNT_W'(full_n[k]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state  <= I_IDLE;
      out_state <= O_IDLE;
      ack_out   <= 1'b0;
      req_out   <= 1'b0;
      full      <= '0;
      count     <= '0;
      for (int k = 0; k < DEPTH; k++) stage_dat[k] <= '0;
    end else begin
      in_state  <= in_state_n;
      out_state <= out_state_n;
      ack_out   <= ack_out_n;
      req_out   <= req_out_n;
      full      <= full_n;
      count     <= count_n;
      if (load[0]) stage_dat[0] <= data_in;
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) stage_dat[k] <= stage_dat[k-1];
      end
    end
  end

  assign data_out = stage_dat[DEPTH-1];

endmodule
